fire_squeeze_ctrl: RTL

FIRE_SQUEEZE_CTRL -- requirements
Module: fire_squeeze_ctrl

---
 rtl/fire_squeeze_ctrl_if.sv | 39 +++
 rtl/fire_squeeze_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fire_squeeze_ctrl_if.sv
// Control/address bundle between the fire squeeze window sequencer and the
// feature-map memory, weight ROM and MAC array.
interface fire_squeeze_ctrl_if #(
    parameter int W_IN       = 128,
    parameter int CHIN       = 64,
    parameter int KERNEL_DIM = 3,
    parameter int STRIDE     = 1,
    parameter int PAD        = 1
);
    localparam int W_OUT = (W_IN + 2*PAD - KERNEL_DIM) / STRIDE + 1;
    localparam int IA_W  = (CHIN*W_IN*W_IN > 1) ? $clog2(CHIN*W_IN*W_IN) : 1;
    localparam int WA_W  = (CHIN*KERNEL_DIM*KERNEL_DIM > 1) ? $clog2(CHIN*KERNEL_DIM*KERNEL_DIM) : 1;
    localparam int OA_W  = (W_OUT*W_OUT > 1) ? $clog2(W_OUT*W_OUT) : 1;

    logic            start;
    logic            hold;
    logic            busy;
    logic [IA_W-1:0] ifm_addr;
    logic            ifm_rd;
    logic            ifm_pad;
    logic [WA_W-1:0] w_addr;
    logic            mac_en;
    logic            mac_clr;
    logic            ofm_valid;
    logic [OA_W-1:0] ofm_addr;
    logic            done;

    modport master (
        input  start, hold,
        output busy, ifm_addr, ifm_rd, ifm_pad, w_addr,
        output mac_en, mac_clr, ofm_valid, ofm_addr, done
    );

    modport slave (
        output start, hold,
        input  busy, ifm_addr, ifm_rd, ifm_pad, w_addr,
        input  mac_en, mac_clr, ofm_valid, ofm_addr, done
    );
endinterface

// File: rtl/fire_squeeze_ctrl.sv
// Convolution window sequencer: walks oy, ox, c, ky, kx and issues one tap per
// cycle, with a 3-stage issue/MAC/result pipeline that freezes under hold.
//   state   | meaning
//   S_IDLE  | waiting for start, counters at zero
//   S_RUN   | issuing taps
//   S_DRAIN | all taps issued, waiting for the final ofm_valid
//   S_DONE  | one-cycle done pulse
module fire_squeeze_ctrl #(
    parameter int W_IN       = 128,
    parameter int CHIN       = 64,
    parameter int KERNEL_DIM = 3,
    parameter int STRIDE     = 1,
    parameter int PAD        = 1
) (
    input logic clk,
    input logic rst,
    fire_squeeze_ctrl_if.master bus
);
    localparam int W_OUT = (W_IN + 2*PAD - KERNEL_DIM) / STRIDE + 1;
    localparam int KK    = KERNEL_DIM * KERNEL_DIM;
    localparam int IA_W  = (CHIN*W_IN*W_IN > 1) ? $clog2(CHIN*W_IN*W_IN) : 1;
    localparam int WA_W  = (CHIN*KK > 1) ? $clog2(CHIN*KK) : 1;
    localparam int OA_W  = (W_OUT*W_OUT > 1) ? $clog2(W_OUT*W_OUT) : 1;
    localparam int O_W   = (W_OUT > 1) ? $clog2(W_OUT) : 1;
    localparam int C_W   = (CHIN > 1) ? $clog2(CHIN) : 1;
    localparam int K_W   = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;

    localparam logic [O_W-1:0] O_MAX = O_W'(W_OUT - 1);
    localparam logic [C_W-1:0] C_MAX = C_W'(CHIN - 1);
    localparam logic [K_W-1:0] K_MAX = K_W'(KERNEL_DIM - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state;

    logic [O_W-1:0] oy, ox;
    logic [C_W-1:0] c;
    logic [K_W-1:0] ky, kx;

    // issue stage
    logic            iss_v, iss_pad, iss_first, iss_last, iss_end;
    logic [IA_W-1:0] iss_ia;
    logic [WA_W-1:0] iss_wa;
    logic [OA_W-1:0] iss_oa;
    // MAC stage
    logic            mac_v, mac_first, mac_last, mac_end;
    logic [OA_W-1:0] mac_oa;
    // result stage
    logic            ofm_v, ofm_end;
    logic [OA_W-1:0] ofm_oa;

    logic busy_q, done_q;

    int              iy, ix;
    logic            tap_pad, tap_first, tap_last, tap_end, issue;
    logic [IA_W-1:0] tap_ia;
    logic [WA_W-1:0] tap_wa;
    logic [OA_W-1:0] tap_oa;

    always_comb begin
        iy        = int'(oy) * STRIDE - PAD + int'(ky);
        ix        = int'(ox) * STRIDE - PAD + int'(kx);
        tap_pad   = (iy < 0) || (iy >= W_IN) || (ix < 0) || (ix >= W_IN);
        tap_ia    = tap_pad ? '0 : IA_W'(int'(c) * W_IN * W_IN + iy * W_IN + ix);
        tap_wa    = WA_W'(int'(c) * KK + int'(ky) * KERNEL_DIM + int'(kx));
        tap_oa    = OA_W'(int'(oy) * W_OUT + int'(ox));
        tap_first = (c == '0) && (ky == '0) && (kx == '0);
        tap_last  = (c == C_MAX) && (ky == K_MAX) && (kx == K_MAX);
        tap_end   = tap_last && (oy == O_MAX) && (ox == O_MAX);
        // start under hold is accepted, but tap 0 waits for hold to drop
        issue     = !bus.hold && ((state == S_IDLE && bus.start) || state == S_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            oy        <= '0;
            ox        <= '0;
            c         <= '0;
            ky        <= '0;
            kx        <= '0;
            iss_v     <= 1'b0;
            iss_pad   <= 1'b0;
            iss_first <= 1'b0;
            iss_last  <= 1'b0;
            iss_end   <= 1'b0;
            iss_ia    <= '0;
            iss_wa    <= '0;
            iss_oa    <= '0;
            mac_v     <= 1'b0;
            mac_first <= 1'b0;
            mac_last  <= 1'b0;
            mac_end   <= 1'b0;
            mac_oa    <= '0;
            ofm_v     <= 1'b0;
            ofm_end   <= 1'b0;
            ofm_oa    <= '0;
        end else begin
            if (!bus.hold) begin
                mac_v     <= iss_v;
                mac_first <= iss_first;
                mac_last  <= iss_last;
                mac_end   <= iss_end;
                mac_oa    <= iss_oa;
                ofm_v     <= mac_v & mac_last;
                ofm_end   <= mac_v & mac_end;
                ofm_oa    <= (mac_v & mac_last) ? mac_oa : '0;
                done_q    <= 1'b0;
            end

            if (issue) begin
                iss_v     <= 1'b1;
                iss_pad   <= tap_pad;
                iss_first <= tap_first;
                iss_last  <= tap_last;
                iss_end   <= tap_end;
                iss_ia    <= tap_ia;
                iss_wa    <= tap_wa;
                iss_oa    <= tap_oa;
                if (kx == K_MAX) begin
                    kx <= '0;
                    if (ky == K_MAX) begin
                        ky <= '0;
                        if (c == C_MAX) begin
                            c <= '0;
                            if (ox == O_MAX) begin
                                ox <= '0;
                                oy <= (oy == O_MAX) ? '0 : oy + 1'b1;
                            end else begin
                                ox <= ox + 1'b1;
                            end
                        end else begin
                            c <= c + 1'b1;
                        end
                    end else begin
                        ky <= ky + 1'b1;
                    end
                end else begin
                    kx <= kx + 1'b1;
                end
            end else if (!bus.hold) begin
                iss_v     <= 1'b0;
                iss_pad   <= 1'b0;
                iss_first <= 1'b0;
                iss_last  <= 1'b0;
                iss_end   <= 1'b0;
                iss_ia    <= '0;
                iss_wa    <= '0;
                iss_oa    <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state  <= (issue && tap_end) ? S_DRAIN : S_RUN;
                        busy_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue && tap_end) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!bus.hold && ofm_v && ofm_end) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!bus.hold) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.ifm_addr  = iss_ia;
    assign bus.ifm_pad   = iss_pad;
    assign bus.ifm_rd    = iss_v & ~iss_pad & ~bus.hold;
    assign bus.w_addr    = iss_wa;
    assign bus.mac_en    = mac_v & ~bus.hold;
    assign bus.mac_clr   = mac_v & mac_first & ~bus.hold;
    assign bus.ofm_valid = ofm_v & ~bus.hold;
    assign bus.ofm_addr  = (ofm_v & ~bus.hold) ? ofm_oa : '0;
    assign bus.done      = done_q & ~bus.hold;
endmodule
